delayed_write_scheduler: RTL and testbench
==========================================

# delayed_write_scheduler

Sequences timed writes into a small register file. Requesters post (address, data, delay) tuples, and the block holds them in pending slots. Each write commits exactly `delay+1` clock edges after acceptance. When several writes to one register fall due on the same edge, last-accepted wins, giving deterministic non-blocking-style update semantics. It sits between stimulus/control logic and the register file it owns, and provides a free-running tick counter for time-stamped monitoring.

## Interface
- `NREG`, 4, number of registers in the file
- `AW`, 2, address width (`2**AW >= NREG`)
- `DW`, 8, register data width
- `NSLOT`, 4, number of pending-write slots
- `DLYW`, 3, delay field width (delay 0..`2**DLYW-1` cycles)
- `TW`, 16, tick counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  write request present
- `req_ready`  out  1  slot available; request is accepted on an edge where valid && ready
- `req_addr`  in  AW  target register
- `req_data`  in  DW  write value
- `req_delay`  in  DLYW  extra cycles before commit
- `rd_addr`  in  AW  read address
- `rd_data`  out  DW  combinational read of register `rd_addr`
- `pending`  out  $clog2(NSLOT+1)  occupied slot count
- `commit_mask`  out  NREG  bit i high for one cycle after register i was written
- `now`  out  TW  tick counter; increments every edge, wraps

## Operation
- Each slot holds valid, addr, data, `remaining` (DLYW bits) and `age` (DLYW+1 bits, saturating).
- Accept: on an edge with `req_valid && req_ready`, load the lowest-index free slot with `remaining = req_delay` and `age = 0`.
- Each later edge, for every valid slot:
  - if `remaining == 0`, the slot is due: it commits and is freed;
  - otherwise decrement `remaining`;
  - `age` increments on every edge.
- Commit resolution per register: among the due slots targeting that register, the one with the smallest `age` (latest accepted) writes. The others are discarded. Distinct registers commit in parallel on the same edge.
- Ages are never equal within one register's due set, because at most one accept happens per edge.
- `req_ready = (pending < NSLOT)`, from registered state only.
  - A slot freed on edge E is usable from edge E+1; there is no same-edge reuse.
- `pending` is updated each edge: `+1` on accept, minus the number of slots freed.
- Address `>= NREG`: the request is accepted, occupies its slot and is freed when due, but writes nothing and sets no mask bit.
- Reset (asynchronous, any time):
  - all registers = 0;
  - all slots invalid, pending writes dropped;
  - `pending = 0`, `commit_mask = 0`, `now = 0`;
  - `req_ready = 1` once reset deasserts.

## Timing
- A request accepted at edge E with delay d updates the register at edge E+1+d.
  - `rd_data` shows the new value in the cycle following that edge.
  - `commit_mask` is asserted during that same cycle.
- Minimum latency is 1 edge (delay 0); maximum is `2**DLYW` edges.
- `now` after edge k reads k (mod `2**TW`); it wraps from `2**TW-1` to 0.
- Full condition: with `pending == NSLOT`, `req_ready` is low. A requester must hold `req_valid` and its fields stable until accepted.
- Commit and accept on the same edge: the commit frees a slot, and the accept takes a slot that was already free. Both are legal as long as `pending < NSLOT` before the edge.

## Test plan
- Reset then single write: addr1 data4 delay0 accepted at edge1 -> `rd_data`(1)=4 after edge2, `commit_mask=0010` for one cycle, `pending` 1 then 0.
- Delayed write: addr0 data5 delay2 at edge1 -> reg0 stays 0 through edge3, becomes 5 after edge4; `now=4` in that cycle.
- Last-accepted wins: addr2 data10 delay1 at edge1, then addr2 data6 delay0 at edge2 -> both due at edge3, reg2=6, never 10; single `commit_mask` bit2 pulse.
- Parallel commit: addr0 data7 delay1 at edge1 and addr3 data9 delay0 at edge2 -> both write at edge3, `commit_mask=1001`.
- Full/back-pressure: 4 requests with delay 7 on consecutive edges -> `pending=4`, `req_ready=0`; a fifth held request is accepted only on the edge after the first slot frees (edge 10 for first accept at edge1).
- Reset mid-operation: queue addr1 data3 delay5, assert `rst` two edges later -> reg1 stays 0 after reset release, `pending=0`, `now=0`, no `commit_mask` pulse.

Source files
------------

// File: rtl/delayed_write_scheduler.sv
// Timed-write scheduler: holds (addr, data, delay) requests in slots and commits
// each one delay+1 edges after acceptance; on a same-edge collision the latest accept wins.
module delayed_write_scheduler #(
  parameter int NREG  = 4,
  parameter int AW    = 2,
  parameter int DW    = 8,
  parameter int NSLOT = 4,
  parameter int DLYW  = 3,
  parameter int TW    = 16,
  localparam int PW   = $clog2(NSLOT + 1),
  localparam int SW   = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_data,
  input  logic [DLYW-1:0] req_delay,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic [PW-1:0]   pending,
  output logic [NREG-1:0] commit_mask,
  output logic [TW-1:0]   now
);

  logic [NSLOT-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [NSLOT];
  logic [AW-1:0]    addr_d [NSLOT];
  logic [DW-1:0]    data_q [NSLOT];
  logic [DW-1:0]    data_d [NSLOT];
  logic [DLYW-1:0]  rem_q  [NSLOT];
  logic [DLYW-1:0]  rem_d  [NSLOT];
  logic [DLYW:0]    age_q  [NSLOT];
  logic [DLYW:0]    age_d  [NSLOT];
  logic [DW-1:0]    regs_q [NREG];
  logic [DW-1:0]    regs_d [NREG];
  logic [PW-1:0]    pending_q, pending_d;
  logic [NREG-1:0]  mask_q, mask_d;
  logic [TW-1:0]    now_q, now_d;

  logic [NSLOT-1:0] due_s;
  logic             accept_s;
  logic             free_found_s;
  logic [SW-1:0]    free_idx_s;
  logic [PW-1:0]    freed_cnt_s;
  logic [DLYW:0]    best_age_s [NREG];
  logic [DW-1:0]    win_data_s [NREG];

  assign req_ready   = (pending_q < PW'(NSLOT));
  assign accept_s    = req_valid && req_ready;
  assign pending     = pending_q;
  assign commit_mask = mask_q;
  assign now         = now_q;
  assign rd_data     = (int'(rd_addr) < NREG) ? regs_q[rd_addr] : '0;

  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    freed_cnt_s  = '0;
    for (int s = 0; s < NSLOT; s++) begin
      due_s[s]    = valid_q[s] && (rem_q[s] == '0);
      freed_cnt_s = freed_cnt_s + PW'(due_s[s]);
      if (!valid_q[s] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = SW'(s);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Per-register winner: the due slot with the smallest age is the most recent accept.
  always_comb begin
    mask_d = '0;
    for (int r = 0; r < NREG; r++) begin
      best_age_s[r] = '1;
      win_data_s[r] = '0;
      for (int s = 0; s < NSLOT; s++) begin
        if (due_s[s] && (int'(addr_q[s]) == r) && (!mask_d[r] || (age_q[s] < best_age_s[r]))) begin
          mask_d[r]     = 1'b1;
          best_age_s[r] = age_q[s];
          win_data_s[r] = data_q[s];
        end else begin
          mask_d[r] = mask_d[r];
        end
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rem_d     = rem_q;
    age_d     = age_q;
    regs_d    = regs_q;
    now_d     = now_q + 1'b1;
    pending_d = pending_q + PW'(accept_s) - freed_cnt_s;
    for (int r = 0; r < NREG; r++) begin
      if (mask_d[r]) regs_d[r] = win_data_s[r];
      else           regs_d[r] = regs_q[r];
    end
    for (int s = 0; s < NSLOT; s++) begin
      if (due_s[s]) begin
        valid_d[s] = 1'b0;
      end else if (valid_q[s]) begin
        rem_d[s] = rem_q[s] - 1'b1;
      end else begin
        rem_d[s] = rem_q[s];
      end
      if (age_q[s] != '1) age_d[s] = age_q[s] + 1'b1;
      else                age_d[s] = age_q[s];
      // Only slots free before this edge are loadable, so a slot freed now is reused next edge.
      if (accept_s && (int'(free_idx_s) == s)) begin
        valid_d[s] = 1'b1;
        addr_d[s]  = req_addr;
        data_d[s]  = req_data;
        rem_d[s]   = req_delay;
        age_d[s]   = '0;
      end else begin
        valid_d[s] = valid_d[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      now_q     <= '0;
      for (int s = 0; s < NSLOT; s++) begin
        addr_q[s] <= '0;
        data_q[s] <= '0;
        rem_q[s]  <= '0;
        age_q[s]  <= '0;
      end
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      now_q     <= now_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      age_q     <= age_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_delayed_write_scheduler.sv
// Directed self-checking bench for delayed_write_scheduler; edge numbers count
// rising edges after reset release.
module tb_delayed_write_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_data = 8'd0;
  logic [2:0] req_delay = 3'd0;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;
  logic [2:0] pending;
  logic [3:0] commit_mask;
  logic [15:0] now;

  int checks = 0;
  int failures = 0;

  delayed_write_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_delay(req_delay),
    .rd_addr(rd_addr), .rd_data(rd_data), .pending(pending),
    .commit_mask(commit_mask), .now(now)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic post(input logic [1:0] a, input logic [7:0] d, input logic [2:0] dl);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_delay = dl;
    step();
    req_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    int acc_edge;
    int pulses;

    // Reset state
    do_reset();
    check("rst_pending", pending, 0);
    check("rst_ready", req_ready, 1);
    check("rst_now", now, 0);
    check("rst_mask", commit_mask, 0);
    rd_check("rst_reg1", 2'd1, 8'd0);

    // Single write, delay 0
    post(2'd1, 8'd4, 3'd0);
    check("t1_pend_e1", pending, 1);
    rd_check("t1_reg1_e1", 2'd1, 8'd0);
    step();
    rd_check("t1_reg1_e2", 2'd1, 8'd4);
    check("t1_mask_e2", commit_mask, 4'b0010);
    check("t1_pend_e2", pending, 0);
    step();
    check("t1_mask_e3", commit_mask, 4'b0000);

    // Delayed write, delay 2
    do_reset();
    post(2'd0, 8'd5, 3'd2);
    rd_check("t2_reg0_e1", 2'd0, 8'd0);
    step();
    rd_check("t2_reg0_e2", 2'd0, 8'd0);
    step();
    rd_check("t2_reg0_e3", 2'd0, 8'd0);
    check("t2_mask_e3", commit_mask, 4'b0000);
    step();
    rd_check("t2_reg0_e4", 2'd0, 8'd5);
    check("t2_now_e4", now, 4);
    check("t2_mask_e4", commit_mask, 4'b0001);

    // Last accepted wins
    do_reset();
    post(2'd2, 8'd10, 3'd1);
    post(2'd2, 8'd6, 3'd0);
    check("t3_pend_e2", pending, 2);
    rd_check("t3_reg2_e2", 2'd2, 8'd0);
    step();
    rd_check("t3_reg2_e3", 2'd2, 8'd6);
    check("t3_mask_e3", commit_mask, 4'b0100);
    check("t3_pend_e3", pending, 0);
    step();
    check("t3_mask_e4", commit_mask, 4'b0000);
    rd_check("t3_reg2_e4", 2'd2, 8'd6);

    // Parallel commit to distinct registers
    do_reset();
    post(2'd0, 8'd7, 3'd1);
    post(2'd3, 8'd9, 3'd0);
    check("t4_mask_e2", commit_mask, 4'b0000);
    step();
    check("t4_mask_e3", commit_mask, 4'b1001);
    rd_check("t4_reg0_e3", 2'd0, 8'd7);
    rd_check("t4_reg3_e3", 2'd3, 8'd9);

    // Full / back-pressure
    do_reset();
    post(2'd0, 8'h11, 3'd7);
    post(2'd1, 8'h22, 3'd7);
    post(2'd2, 8'h33, 3'd7);
    post(2'd3, 8'h44, 3'd7);
    check("t5_pend_full", pending, 4);
    check("t5_ready_full", req_ready, 0);
    req_valid = 1'b1;
    req_addr  = 2'd1;
    req_data  = 8'h55;
    req_delay = 3'd0;
    acc_edge  = -1;
    for (int e = 5; e <= 20 && acc_edge < 0; e++) begin
      if (req_ready) acc_edge = e;
      step();
      if (e == 9) begin
        check("t5_mask_e9", commit_mask, 4'b0001);
        check("t5_pend_e9", pending, 3);
      end
    end
    req_valid = 1'b0;
    check("t5_accept_edge", acc_edge, 10);
    check("t5_pend_e10", pending, 3);
    rd_check("t5_reg1_e10", 2'd1, 8'h22);
    step();
    rd_check("t5_reg1_e11", 2'd1, 8'h55);
    check("t5_mask_e11", commit_mask, 4'b0110);

    // Reset mid-operation
    do_reset();
    post(2'd1, 8'd3, 3'd5);
    step();
    rst = 1'b1;
    #1;
    check("t6_pend_in_rst", pending, 0);
    step();
    step();
    rst = 1'b0;
    check("t6_pend_rel", pending, 0);
    check("t6_now_rel", now, 0);
    check("t6_ready_rel", req_ready, 1);
    pulses = 0;
    rd_addr = 2'd1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (commit_mask != 4'b0000) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    rd_check("t6_reg1", 2'd1, 8'd0);
    check("t6_now_e10", now, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
